// File: rtl/sm83_irq_sequencer.sv
// SM83 interrupt/HALT controller. Tracks IME and HALT state and runs the
// interrupt dispatch (wait, push PCH, push PCL, jump) alongside the M-cycle sequencer.
module sm83_irq_sequencer #(
  parameter int         NUM_IRQ    = 5,
  parameter logic [7:0] VEC_BASE   = 8'h40,
  parameter logic [7:0] VEC_STRIDE = 8'h08,
  parameter int         WAIT_MCYC  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               t4,
  input  logic               fetch_done,
  input  logic [NUM_IRQ-1:0] if_in,
  input  logic [NUM_IRQ-1:0] ie_in,
  input  logic               ime_set,
  input  logic               ime_set_now,
  input  logic               ime_clr,
  input  logic               halt,
  output logic               ime,
  output logic               halted,
  output logic               disp_active,
  output logic [2:0]         disp_state,
  output logic               wr_pch,
  output logic               wr_pcl,
  output logic               load_vec,
  output logic [7:0]         vector,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               set_m1
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int CNT_W = (WAIT_MCYC > 1) ? $clog2(WAIT_MCYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MCYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HALTED  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PUSH_HI = 3'd3,
    ST_PUSH_LO = 3'd4,
    ST_JUMP    = 3'd5
  } state_t;

  // Index 0 is the highest priority, so scan downwards and keep the last hit.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_IRQ-1:0] req);
    lowest_idx = {IDX_W{1'b0}};
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               ime_r, ime_pend_r, halted_r;
  logic               wr_pch_r, wr_pcl_r, load_vec_r, disp_active_r;
  logic [7:0]         vector_r;
  logic [NUM_IRQ-1:0] req_s, ack_s;
  logic               pending_s, ime_eff_s, enter_wait_s, set_m1_s, boundary_s;
  logic [IDX_W-1:0]   sel_s;
  logic [7:0]         sel8_s, vec_calc_s;

  assign req_s      = if_in & ie_in;
  assign pending_s  = |req_s;
  assign ime_eff_s  = ime_r | ime_pend_r;
  assign sel_s      = lowest_idx(req_s);
  assign sel8_s     = 8'(sel_s);
  assign vec_calc_s = VEC_BASE + sel8_s * VEC_STRIDE;
  assign boundary_s = t4 & fetch_done & (state_r == ST_IDLE);

  // Next-state decode; every transition is qualified by the t4 strobe.
  always_comb begin
    state_nxt_s  = state_r;
    enter_wait_s = 1'b0;
    set_m1_s     = 1'b0;
    if (t4) begin
      case (state_r)
        ST_IDLE: begin
          if (fetch_done && ime_eff_s && pending_s) begin
            state_nxt_s  = ST_WAIT;
            enter_wait_s = 1'b1;
          end else if (fetch_done && halt) begin
            state_nxt_s = ST_HALTED;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_HALTED: begin
          if (pending_s && ime_r) begin
            state_nxt_s  = ST_WAIT;
            enter_wait_s = 1'b1;
          end else if (pending_s) begin
            state_nxt_s = ST_IDLE;
            set_m1_s    = 1'b1;
          end else begin
            state_nxt_s = ST_HALTED;
          end
        end
        ST_WAIT: begin
          if (cnt_r == CNT_LAST) state_nxt_s = ST_PUSH_HI;
          else                   state_nxt_s = ST_WAIT;
        end
        ST_PUSH_HI: state_nxt_s = ST_PUSH_LO;
        ST_PUSH_LO: state_nxt_s = ST_JUMP;
        ST_JUMP: begin
          state_nxt_s = ST_IDLE;
          set_m1_s    = 1'b1;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Acknowledge and restart pulses coincide with t4 and are suppressed under reset.
  always_comb begin
    ack_s   = {NUM_IRQ{1'b0}};
    set_m1  = 1'b0;
    irq_ack = {NUM_IRQ{1'b0}};
    if (pending_s) ack_s = NUM_IRQ'(1'b1) << sel_s;
    else           ack_s = {NUM_IRQ{1'b0}};
    if (!reset) begin
      set_m1 = set_m1_s;
      if (t4 && state_r == ST_PUSH_HI) irq_ack = ack_s;
      else                             irq_ack = {NUM_IRQ{1'b0}};
    end else begin
      set_m1  = 1'b0;
      irq_ack = {NUM_IRQ{1'b0}};
    end
  end

  // State, wait counter, IME bookkeeping and registered M-cycle strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      ime_r         <= 1'b0;
      ime_pend_r    <= 1'b0;
      halted_r      <= 1'b0;
      vector_r      <= 8'h00;
      wr_pch_r      <= 1'b0;
      wr_pcl_r      <= 1'b0;
      load_vec_r    <= 1'b0;
      disp_active_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      halted_r      <= (state_nxt_s == ST_HALTED);
      wr_pch_r      <= (state_nxt_s == ST_PUSH_HI);
      wr_pcl_r      <= (state_nxt_s == ST_PUSH_LO);
      load_vec_r    <= (state_nxt_s == ST_JUMP);
      disp_active_r <= (state_nxt_s == ST_WAIT) || (state_nxt_s == ST_PUSH_HI) ||
                       (state_nxt_s == ST_PUSH_LO) || (state_nxt_s == ST_JUMP);
      if (enter_wait_s)                    cnt_r <= {CNT_W{1'b0}};
      else if (t4 && state_r == ST_WAIT)   cnt_r <= cnt_r + CNT_W'(1);
      if (t4 && state_r == ST_PUSH_HI)     vector_r <= pending_s ? vec_calc_s : 8'h00;
      if (t4) begin
        if (ime_clr || enter_wait_s) begin
          ime_r      <= 1'b0;
          ime_pend_r <= 1'b0;
        end else begin
          // EI takes effect one instruction late: the pending flag promotes at the next boundary.
          if (ime_set_now || (boundary_s && ime_pend_r)) ime_r <= 1'b1;
          if (boundary_s) ime_pend_r <= ime_set;
        end
      end
    end
  end

  assign ime         = ime_r;
  assign halted      = halted_r;
  assign disp_active = disp_active_r;
  assign disp_state  = state_r;
  assign wr_pch      = wr_pch_r;
  assign wr_pcl      = wr_pcl_r;
  assign load_vec    = load_vec_r;
  assign vector      = vector_r;

endmodule

// File: tb/tb_sm83_irq_sequencer.sv
// Directed bench for sm83_irq_sequencer: one table row per M-cycle (inputs held for
// four clocks, t4 on the last) with expected pulses during t4 and state after it.
module tb_sm83_irq_sequencer;

  logic       clk = 1'b0;
  logic       reset, t4, fetch_done, ime_set, ime_set_now, ime_clr, halt;
  logic [4:0] if_in, ie_in, irq_ack;
  logic       ime, halted, disp_active, wr_pch, wr_pcl, load_vec, set_m1;
  logic [2:0] disp_state;
  logic [7:0] vector;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sm83_irq_sequencer dut (
    .clk(clk), .reset(reset), .t4(t4), .fetch_done(fetch_done),
    .if_in(if_in), .ie_in(ie_in), .ime_set(ime_set), .ime_set_now(ime_set_now),
    .ime_clr(ime_clr), .halt(halt), .ime(ime), .halted(halted),
    .disp_active(disp_active), .disp_state(disp_state), .wr_pch(wr_pch),
    .wr_pcl(wr_pcl), .load_vec(load_vec), .vector(vector), .irq_ack(irq_ack),
    .set_m1(set_m1)
  );

  typedef struct packed {
    logic       fd;
    logic [4:0] ifv;
    logic [4:0] iev;
    logic       ei, di, reti, hlt;
    logic       m1;
    logic [4:0] ack;
    logic [2:0] st;
    logic       ime;
    logic       hal;
    logic [7:0] vec;
  } row_t;

  row_t rows[$];

  function automatic row_t mk(input logic fd, input logic [4:0] ifv, input logic [4:0] iev,
                              input logic ei, input logic di, input logic reti, input logic hlt,
                              input logic m1, input logic [4:0] ack, input logic [2:0] st,
                              input logic im, input logic hal, input logic [7:0] vec);
    mk = {fd, ifv, iev, ei, di, reti, hlt, m1, ack, st, im, hal, vec};
  endfunction

  task automatic add(input logic fd, input logic [4:0] ifv, input logic [4:0] iev,
                     input logic ei, input logic di, input logic reti, input logic hlt,
                     input logic m1, input logic [4:0] ack, input logic [2:0] st,
                     input logic im, input logic hal, input logic [7:0] vec);
    rows.push_back(mk(fd, ifv, iev, ei, di, reti, hlt, m1, ack, st, im, hal, vec));
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  // One M-cycle: called and returning at a negedge.
  task automatic step(input int idx, input row_t r);
    logic [2:0] strobes;
    logic       act_exp;
    fetch_done = r.fd; if_in = r.ifv; ie_in = r.iev;
    ime_set = r.ei; ime_clr = r.di; ime_set_now = r.reti; halt = r.hlt; t4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("set_m1_without_t4", idx, {31'd0, set_m1}, 32'd0);
    t4 = 1'b1;
    #1;
    chk("set_m1", idx, {31'd0, set_m1}, {31'd0, r.m1});
    chk("irq_ack", idx, {27'd0, irq_ack}, {27'd0, r.ack});
    @(negedge clk);
    t4 = 1'b0;
    strobes = {r.st == 3'd3, r.st == 3'd4, r.st == 3'd5};
    act_exp = (r.st >= 3'd2) && (r.st <= 3'd5);
    chk("disp_state", idx, {29'd0, disp_state}, {29'd0, r.st});
    chk("ime", idx, {31'd0, ime}, {31'd0, r.ime});
    chk("halted", idx, {31'd0, halted}, {31'd0, r.hal});
    chk("vector", idx, {24'd0, vector}, {24'd0, r.vec});
    chk("strobes", idx, {29'd0, wr_pch, wr_pcl, load_vec}, {29'd0, strobes});
    chk("disp_active", idx, {31'd0, disp_active}, {31'd0, act_exp});
  endtask

  initial begin
    reset = 1'b1; t4 = 1'b0; fetch_done = 1'b0; if_in = 5'h00; ie_in = 5'h00;
    ime_set = 1'b0; ime_set_now = 1'b0; ime_clr = 1'b0; halt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 0, {29'd0, disp_state}, 32'd0);
    chk("rst_flags", 0, {26'd0, ime, halted, disp_active, wr_pch, wr_pcl, load_vec}, 32'd0);
    chk("rst_vector", 0, {24'd0, vector}, 32'd0);
    chk("rst_pulses", 0, {26'd0, set_m1, irq_ack}, 32'd0);
    reset = 1'b0;

    //    fd  if     ie     ei    di    reti  hlt | m1  ack    st    ime   hal   vec
    // Dispatch of source 2 with IME already set.
    add(1'b0, 5'h00, 5'h1F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'h00, 3'd0, 1'b1, 1'b0, 8'h00);
    add(1'b1, 5'h04, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd2, 1'b0, 1'b0, 8'h00);
    add(1'b0, 5'h04, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd2, 1'b0, 1'b0, 8'h00);
    add(1'b0, 5'h04, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd3, 1'b0, 1'b0, 8'h00);
    add(1'b0, 5'h04, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h04, 3'd4, 1'b0, 1'b0, 8'h50);
    add(1'b0, 5'h00, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd5, 1'b0, 1'b0, 8'h50);
    add(1'b0, 5'h00, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00, 3'd0, 1'b0, 1'b0, 8'h50);
    // Lowest enabled source wins.
    add(1'b0, 5'h00, 5'h1E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'h00, 3'd0, 1'b1, 1'b0, 8'h50);
    add(1'b1, 5'h1F, 5'h1E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd2, 1'b0, 1'b0, 8'h50);
    add(1'b0, 5'h1F, 5'h1E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd2, 1'b0, 1'b0, 8'h50);
    add(1'b0, 5'h1F, 5'h1E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd3, 1'b0, 1'b0, 8'h50);
    add(1'b0, 5'h1F, 5'h1E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h02, 3'd4, 1'b0, 1'b0, 8'h48);
    add(1'b0, 5'h1D, 5'h1E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd5, 1'b0, 1'b0, 8'h48);
    add(1'b0, 5'h1D, 5'h1E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00, 3'd0, 1'b0, 1'b0, 8'h48);
    // EI delays one instruction, then dispatch at the NOP boundary.
    add(1'b1, 5'h01, 5'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 1'b0, 1'b0, 8'h48);
    add(1'b1, 5'h01, 5'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd2, 1'b0, 1'b0, 8'h48);
    add(1'b0, 5'h01, 5'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd2, 1'b0, 1'b0, 8'h48);
    add(1'b0, 5'h01, 5'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd3, 1'b0, 1'b0, 8'h48);
    add(1'b0, 5'h01, 5'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h01, 3'd4, 1'b0, 1'b0, 8'h40);
    add(1'b0, 5'h00, 5'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd5, 1'b0, 1'b0, 8'h40);
    add(1'b0, 5'h00, 5'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00, 3'd0, 1'b0, 1'b0, 8'h40);
    // EI and DI on the same boundary: IME never comes up.
    add(1'b1, 5'h00, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 1'b0, 1'b0, 8'h40);
    add(1'b1, 5'h00, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 1'b0, 1'b0, 8'h40);
    // HALT with IME=0: wake to IDLE with set_m1, no push.
    add(1'b1, 5'h00, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 3'd1, 1'b0, 1'b1, 8'h40);
    add(1'b0, 5'h00, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd1, 1'b0, 1'b1, 8'h40);
    add(1'b0, 5'h08, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00, 3'd0, 1'b0, 1'b0, 8'h40);
    // HALT with IME=1: wake straight into dispatch of source 3.
    add(1'b0, 5'h00, 5'h1F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'h00, 3'd0, 1'b1, 1'b0, 8'h40);
    add(1'b1, 5'h00, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 3'd1, 1'b1, 1'b1, 8'h40);
    add(1'b0, 5'h08, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd2, 1'b0, 1'b0, 8'h40);
    add(1'b0, 5'h08, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd2, 1'b0, 1'b0, 8'h40);
    add(1'b0, 5'h08, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd3, 1'b0, 1'b0, 8'h40);
    add(1'b0, 5'h08, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h08, 3'd4, 1'b0, 1'b0, 8'h58);
    add(1'b0, 5'h00, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd5, 1'b0, 1'b0, 8'h58);
    add(1'b0, 5'h00, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00, 3'd0, 1'b0, 1'b0, 8'h58);

    foreach (rows[i]) step(i, rows[i]);

    // Cancel: IE dropped during PUSH_HI, pushes and jump still run with vector 00.
    step(100, mk(1'b0, 5'h00, 5'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'h00, 3'd0, 1'b1, 1'b0, 8'h58));
    step(101, mk(1'b1, 5'h01, 5'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd2, 1'b0, 1'b0, 8'h58));
    step(102, mk(1'b0, 5'h01, 5'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd2, 1'b0, 1'b0, 8'h58));
    step(103, mk(1'b0, 5'h01, 5'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd3, 1'b0, 1'b0, 8'h58));
    step(104, mk(1'b0, 5'h01, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd4, 1'b0, 1'b0, 8'h00));
    step(105, mk(1'b0, 5'h01, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd5, 1'b0, 1'b0, 8'h00));
    step(106, mk(1'b0, 5'h01, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h00, 3'd0, 1'b0, 1'b0, 8'h00));

    // Reset in the middle of PUSH_LO aborts the dispatch.
    step(200, mk(1'b0, 5'h00, 5'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'h00, 3'd0, 1'b1, 1'b0, 8'h00));
    step(201, mk(1'b1, 5'h02, 5'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd2, 1'b0, 1'b0, 8'h00));
    step(202, mk(1'b0, 5'h02, 5'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd2, 1'b0, 1'b0, 8'h00));
    step(203, mk(1'b0, 5'h02, 5'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd3, 1'b0, 1'b0, 8'h00));
    step(204, mk(1'b0, 5'h02, 5'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h02, 3'd4, 1'b0, 1'b0, 8'h48));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_state", 300, {29'd0, disp_state}, 32'd0);
    chk("midrst_flags", 300, {26'd0, ime, halted, disp_active, wr_pch, wr_pcl, load_vec}, 32'd0);
    chk("midrst_vector", 300, {24'd0, vector}, 32'd0);
    chk("midrst_pulses", 300, {26'd0, set_m1, irq_ack}, 32'd0);
    reset = 1'b0;
    step(301, mk(1'b0, 5'h02, 5'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'd0, 1'b0, 1'b0, 8'h00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
